// File: rtl/if_id_if.sv
// IF/ID stage bundle: hazard/redirect controls, instruction-memory read port
// and the registered ID-stage outputs.
// The stall_cnt member exists only when STALL_CNT_EN is defined.
// master: the controller / instruction-memory side. slave: the stage.
interface if_id_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_inst;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [31:0] id_inst;
  logic [31:0] id_pc4;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_valid;
`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt;

  modport master (
    output stall, branch_taken, branch_target, imem_inst,
    input  if_pc, if_inst, id_inst, id_pc4, id_rs, id_rt, id_valid, stall_cnt
  );

  modport slave (
    input  stall, branch_taken, branch_target, imem_inst,
    output if_pc, if_inst, id_inst, id_pc4, id_rs, id_rt, id_valid, stall_cnt
  );
`else
  modport master (
    output stall, branch_taken, branch_target, imem_inst,
    input  if_pc, if_inst, id_inst, id_pc4, id_rs, id_rt, id_valid
  );

  modport slave (
    input  stall, branch_taken, branch_target, imem_inst,
    output if_pc, if_inst, id_inst, id_pc4, id_rs, id_rt, id_valid
  );
`endif
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline stage: PC register, ID-stage instruction register, and a
// bounded stall mechanism (at most STALL_MAX consecutive held cycles before
// the stage advances anyway so a stuck hazard cannot deadlock fetch).
// Optional feature macro STALL_CNT_EN adds a saturating held-fetch counter.
module if_id_stage #(
  parameter int unsigned STALL_MAX = 2,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input logic    clk,
  input logic    rst,
  if_id_if.slave bus
);

  typedef enum logic {RUN, HOLD} state_t;

  localparam logic [3:0] SC_MAX = 4'(STALL_MAX);

  state_t      state, state_nxt;
  logic [3:0]  sc, sc_nxt;
  logic        hold_now;

  logic [31:0] pc_p0, pc_nxt;
  logic [31:0] inst_p1, inst_nxt;
  logic [31:0] pc4_p1, pc4_nxt;
  logic        vld_p1, vld_nxt;

  // Sequential fetch address; wraps modulo 2^32.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // Redirect targets are word aligned: the low two bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  // Next-state and next-register selection: redirect beats stall beats advance.
  always_comb begin
    state_nxt = RUN;
    sc_nxt    = 4'd0;
    hold_now  = 1'b0;
    pc_nxt    = pc_inc(pc_p0);
    inst_nxt  = bus.imem_inst;
    pc4_nxt   = pc_inc(pc_p0);
    vld_nxt   = 1'b1;

    if (bus.branch_taken) begin
      pc_nxt   = word_align(bus.branch_target);
      inst_nxt = 32'd0;
      pc4_nxt  = pc4_p1;
      vld_nxt  = 1'b0;
    end else begin
      unique case (state)
        RUN:  hold_now = bus.stall;
        HOLD: hold_now = bus.stall && (sc < SC_MAX);
        default: hold_now = 1'b0;
      endcase
      if (hold_now) begin
        state_nxt = HOLD;
        sc_nxt    = sc + 4'd1;
        pc_nxt    = pc_p0;
        inst_nxt  = 32'd0;
        pc4_nxt   = pc4_p1;
        vld_nxt   = 1'b0;
      end
    end
  end

  // Control state: FSM state and consecutive-stall count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      sc    <= 4'd0;
    end else begin
      state <= state_nxt;
      sc    <= sc_nxt;
    end
  end

  // --- IF stage (p0): fetch address register ---
  always_ff @(posedge clk) begin
    if (rst) pc_p0 <= RESET_PC;
    else     pc_p0 <= pc_nxt;
  end

  // --- ID stage (p1): instruction, return address and valid ---
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_p1 <= 32'd0;
      pc4_p1  <= 32'd0;
      vld_p1  <= 1'b0;
    end else begin
      inst_p1 <= inst_nxt;
      pc4_p1  <= pc4_nxt;
      vld_p1  <= vld_nxt;
    end
  end

`ifdef STALL_CNT_EN
  logic [31:0] cnt_p1;

  // Saturating count of honoured stall cycles only.
  always_ff @(posedge clk) begin
    if (rst)                                    cnt_p1 <= 32'd0;
    else if (hold_now && cnt_p1 != 32'hFFFF_FFFF) cnt_p1 <= cnt_p1 + 32'd1;
  end

  assign bus.stall_cnt = cnt_p1;
`endif

  assign bus.if_pc    = pc_p0;
  assign bus.if_inst  = bus.imem_inst;
  assign bus.id_inst  = inst_p1;
  assign bus.id_pc4   = pc4_p1;
  assign bus.id_rs    = inst_p1[25:21];
  assign bus.id_rt    = inst_p1[20:16];
  assign bus.id_valid = vld_p1;

endmodule

// File: tb/tb_if_id_stage.sv
// Testbench for if_id_stage: directed scenarios with literal expectations,
// then randomized control traffic checked every cycle against a reference.
module tb_if_id_stage;

  localparam int unsigned STALL_MAX = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic chk_en = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  if_id_if bus ();

  if_id_stage #(.STALL_MAX(STALL_MAX), .RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory: each word is tagged with its own address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {16'hC0DE, a[15:0]} ^ {a[31:16], 16'h0000};
  endfunction

  assign bus.imem_inst = mem(bus.if_pc);

  // Reference state
  logic [31:0] m_pc, m_inst, m_pc4, m_cnt;
  logic        m_vld;
  int          m_run;

  always @(posedge clk) begin
    if (rst) begin
      m_pc = 32'd0; m_inst = 32'd0; m_pc4 = 32'd0; m_vld = 1'b0; m_run = 0; m_cnt = 32'd0;
    end else if (bus.branch_taken) begin
      m_pc = {bus.branch_target[31:2], 2'b00}; m_inst = 32'd0; m_vld = 1'b0; m_run = 0;
    end else if (bus.stall && m_run < STALL_MAX) begin
      m_inst = 32'd0; m_vld = 1'b0; m_run = m_run + 1;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    end else begin
      m_inst = mem(m_pc); m_pc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4; m_vld = 1'b1; m_run = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the reference.
  always @(negedge clk) begin
    if (chk_en) begin
      check("if_pc", bus.if_pc, m_pc);
      check("if_inst", bus.if_inst, mem(m_pc));
      check("id_inst", bus.id_inst, m_inst);
      check("id_pc4", bus.id_pc4, m_pc4);
      check("id_rs", 32'(bus.id_rs), 32'(m_inst[25:21]));
      check("id_rt", 32'(bus.id_rt), 32'(m_inst[20:16]));
      check("id_valid", 32'(bus.id_valid), 32'(m_vld));
`ifdef STALL_CNT_EN
      check("stall_cnt", bus.stall_cnt, m_cnt);
`endif
    end
  end

  task automatic cyc(input logic r, input logic s, input logic b, input logic [31:0] t);
    @(negedge clk);
    rst = r; bus.stall = s; bus.branch_taken = b; bus.branch_target = t;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 32'd0;

    // Reset, with stall and branch asserted to show they are ignored.
    cyc(1, 1, 1, 32'h0000_1234);
    chk_en = 1'b1;
    check("rst_pc", bus.if_pc, 32'h0);
    check("rst_id_inst", bus.id_inst, 32'h0);
    check("rst_id_pc4", bus.id_pc4, 32'h0);
    check("rst_valid", 32'(bus.id_valid), 32'h0);

    // Straight-line fetch: one-cycle fetch-to-ID latency.
    cyc(0, 0, 0, 0);
    check("adv1_pc", bus.if_pc, 32'h4);
    check("adv1_inst", bus.id_inst, 32'hC0DE_0000);
    check("adv1_valid", 32'(bus.id_valid), 32'h1);
    cyc(0, 0, 0, 0);
    check("adv2_pc", bus.if_pc, 32'h8);
    check("adv2_pc4", bus.id_pc4, 32'h8);

    // Single stall at pc 8.
    cyc(0, 1, 0, 0);
    check("st_pc", bus.if_pc, 32'h8);
    check("st_inst", bus.id_inst, 32'h0);
    check("st_valid", 32'(bus.id_valid), 32'h0);
    cyc(0, 0, 0, 0);
    check("st_after_pc", bus.if_pc, 32'hC);
    check("st_after_inst", bus.id_inst, 32'hC0DE_0008);
    cyc(0, 0, 0, 0);
    check("pc_10", bus.if_pc, 32'h10);

    // Permanent stall: two held cycles then a forced advance.
    cyc(0, 1, 0, 0); check("ps1", bus.if_pc, 32'h10);
    cyc(0, 1, 0, 0); check("ps2", bus.if_pc, 32'h10);
    cyc(0, 1, 0, 0); check("ps3", bus.if_pc, 32'h14);
    check("ps3_inst", bus.id_inst, 32'hC0DE_0010);
    cyc(0, 1, 0, 0); check("ps4", bus.if_pc, 32'h14);
    cyc(0, 1, 0, 0); check("ps5", bus.if_pc, 32'h14);
    cyc(0, 1, 0, 0); check("ps6", bus.if_pc, 32'h18);
`ifdef STALL_CNT_EN
    check("ps_cnt", bus.stall_cnt, 32'd5);
`endif

    // Redirect wins over a stall; target low bits dropped.
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 32'h0000_0043);
    check("br_pc", bus.if_pc, 32'h40);
    check("br_inst", bus.id_inst, 32'h0);
    check("br_valid", 32'(bus.id_valid), 32'h0);
`ifdef STALL_CNT_EN
    check("br_cnt", bus.stall_cnt, 32'd6);
`endif
    // Fresh stall budget after the redirect: two more held cycles.
    cyc(0, 1, 0, 0); check("br_st1", bus.if_pc, 32'h40);
    cyc(0, 1, 0, 0); check("br_st2", bus.if_pc, 32'h40);

    // Reset while holding discards the held state.
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(1, 1, 1, 32'h0000_0800);
    check("rh_pc", bus.if_pc, 32'h0);
    check("rh_valid", 32'(bus.id_valid), 32'h0);
    check("rh_pc4", bus.id_pc4, 32'h0);
`ifdef STALL_CNT_EN
    check("rh_cnt", bus.stall_cnt, 32'd0);
`endif
    cyc(0, 0, 0, 0);
    check("rh_fetch", bus.id_inst, 32'hC0DE_0000);

    // PC wrap at the top of the address space.
    cyc(0, 0, 1, 32'hFFFF_FFFE);
    check("wrap_pre", bus.if_pc, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0);
    check("wrap_pc", bus.if_pc, 32'h0);
    check("wrap_pc4", bus.id_pc4, 32'h0);
    check("wrap_inst", bus.id_inst, 32'h3F21_FFFC);

    // Randomized traffic: stall bursts, redirects, rare resets.
    for (int i = 0; i < 3000; i++) begin
      logic r, s, b;
      logic [31:0] t;
      r = ($urandom_range(0, 99) == 0);
      b = ($urandom_range(0, 9) == 0);
      s = ($urandom_range(0, 2) != 0) || (i % 200 > 180);
      t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      cyc(r, s, b, t);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have parameter STALL_MAX, default 2: maximum consecutive stall cycles honoured before a forced advance (legal range 1..15).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000: fetch address after reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 stall  input  1  hazard request from the forwarding/stall controller: hold PC and bubble ID.
REQ-006 branch_taken  input  1  branch resolved taken in ID/EX; redirect fetch.
REQ-007 branch_target  input  32  redirect address, word aligned.
REQ-008 imem_inst  input  32  instruction at if_pc, combinational instruction-memory read.
REQ-009 if_pc  output  32  current fetch address to instruction memory.
REQ-010 if_inst  output  32  imem_inst passed through combinationally, for hazard detection.
REQ-011 id_inst  output  32  registered ID-stage instruction; 0 (NOP) when a bubble.
REQ-012 id_pc4  output  32  registered if_pc+4 of the instruction in ID.
REQ-013 id_rs  output  5  id_inst[25:21].
REQ-014 id_rt  output  5  id_inst[20:16].
REQ-015 id_valid  output  1  ID holds a real instruction, not a bubble.
REQ-016 stall_cnt  output  32  held-fetch cycle count; present only with STALL_CNT_EN.

Function
REQ-017 FSM states RUN and HOLD; 4-bit consecutive-stall counter sc.
REQ-018 Priority per cycle: rst > branch_taken > honoured stall > normal advance.
REQ-019 Normal advance, RUN with stall=0: if_pc <= if_pc+4; id_inst <= imem_inst; id_pc4 <= if_pc+4; id_valid <= 1; sc <= 0.
REQ-020 Honoured stall (stall=1, sc<STALL_MAX): if_pc held; id_inst <= 0; id_pc4 held; id_valid <= 0; sc <= sc+1; next state HOLD.
REQ-021 Forced advance (stall=1, sc==STALL_MAX): stall is ignored and the cycle behaves as a normal advance; sc <= 0; next state RUN.
REQ-022 In HOLD, stall=0: normal advance; next state RUN; sc <= 0.
REQ-023 branch_taken=1 in any state: if_pc <= branch_target; id_inst <= 0; id_valid <= 0; sc <= 0; next state RUN. This applies even when stall=1.
REQ-024 if_pc+4 SHALL wrap modulo 2^32, so 32'hFFFF_FFFC advances to 0.
REQ-025 branch_target[1:0] SHALL be ignored and forced to 00.
REQ-026 if_inst SHALL equal imem_inst with zero latency. id_rs and id_rt SHALL be decoded from the id_inst register with no additional latency.
REQ-027 Fetch-to-ID latency SHALL be exactly 1 cycle when no stall or redirect is pending.

Reset
REQ-028 With rst=1 at a clock edge: if_pc=RESET_PC, id_inst=0, id_pc4=0, id_valid=0, sc=0, state RUN, stall_cnt=0. This holds regardless of stall or branch_taken.
REQ-029 rst asserted mid-HOLD SHALL discard the held state. The first post-reset fetch is at RESET_PC.

Configuration
REQ-030 With STALL_CNT_EN defined:
- stall_cnt SHALL increment by 1 on every honoured-stall cycle (REQ-020).
- It SHALL saturate at 32'hFFFF_FFFF.
- It SHALL not count forced advances or redirects.
REQ-031 Without STALL_CNT_EN: the stall_cnt port and its register SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 Reset, then 4 cycles with stall=0 and imem_inst=pc-tagged words -> if_pc 0,4,8,C,10; id_inst follows one cycle behind; id_valid=1 from cycle 2.
REQ-033 stall=1 for 1 cycle at if_pc=8 -> if_pc stays 8 for 2 cycles; id_inst=0 and id_valid=0 for one cycle; the instruction at 8 reaches ID the following cycle.
REQ-034 stall held high permanently, STALL_MAX=2, starting at if_pc=10 -> pattern of 2 held cycles then 1 advance, repeating (10,10,10,14,14,14,18...); with STALL_CNT_EN, stall_cnt=4 after 6 cycles.
REQ-035 branch_taken=1 with stall=1 and branch_target=32'h0000_0043 -> next if_pc=32'h40; id_inst=0; sc=0; stall_cnt unchanged.
REQ-036 if_pc=32'hFFFF_FFFC with stall=0 -> next if_pc=0 and id_pc4=0.
REQ-037 rst pulsed while in HOLD with sc=1 -> all outputs at reset values next cycle; subsequent fetch at RESET_PC.
